mem_unit: RTL and testbench

MEM_UNIT -- requirements
Module: mem_unit

---
 rtl/mem_unit.sv | 123 ++++++++++++
 tb/tb_mem_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_unit.sv
// Loader-filled word memory: holds the CPU in reset while words stream in, then serves CPU accesses.
// Define MEM_PARITY_EN to store an even-parity bit per word and flag read mismatches on perr.
module mem_unit #(
  parameter int unsigned AW        = 12,
  parameter int unsigned DW        = 16,
  parameter int unsigned LOAD_BASE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_hold,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          perr
);

  localparam int unsigned Depth = 1 << AW;

  typedef enum logic [0:0] {StLoad, StRun} state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic [AW-1:0] r_ptr;
  logic [DW-1:0] r_mem [Depth];

  logic w_ld_acc;
  logic w_ld_done;
  logic w_run;
  logic w_cpu_wr;
  logic w_cpu_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StLoad;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StLoad:  if (w_ld_done) w_state_next = StRun;
      StRun:   w_state_next = StRun;
      default: w_state_next = StLoad;
    endcase
  end

  // Reset overrides the state decode so the loader is refused during the reset cycle.
  always_comb begin
    ld_ready = 1'b0;
    cpu_hold = 1'b1;
    w_run    = 1'b0;
    if (!reset) begin
      case (r_state)
        StLoad: ld_ready = 1'b1;
        StRun: begin
          cpu_hold = 1'b0;
          w_run    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_ld_acc  = ld_valid & ld_ready;
  assign w_ld_done = w_ld_acc & (ld_last | (r_ptr == '1));
  assign w_cpu_wr  = w_run & ~cpu_we;
  assign w_cpu_rd  = w_run & cpu_we;

  // The pointer saturates at the top address; the load ends there instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= AW'(LOAD_BASE);
    end else if (w_ld_acc && (r_ptr != '1)) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ld_acc) begin
      r_mem[r_ptr] <= ld_data;
    end else if (w_cpu_wr) begin
      r_mem[cpu_addr] <= cpu_wdata;
    end
  end

  assign cpu_rdata = w_cpu_rd ? r_mem[cpu_addr] : '0;

`ifdef MEM_PARITY_EN
  logic r_par [Depth];
  logic r_perr;
  logic w_par_bad;

  always_ff @(posedge clk) begin
    if (w_ld_acc) begin
      r_par[r_ptr] <= ^ld_data;
    end else if (w_cpu_wr) begin
      r_par[cpu_addr] <= ^cpu_wdata;
    end
  end

  assign w_par_bad = w_cpu_rd & ((^r_mem[cpu_addr]) != r_par[cpu_addr]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perr <= 1'b0;
    end else if (w_par_bad) begin
      r_perr <= 1'b1;
    end
  end

  assign perr = r_perr;
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_unit.sv
// Self-checking bench for mem_unit: directed vectors plus randomized traffic against an array model.
module tb_mem_unit;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;
  localparam int unsigned Depth = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_reset, a_we, a_hold, a_ldv, a_ldl, a_ldr, a_perr;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata, a_ldd;
  logic          b_reset, b_we, b_hold, b_ldv, b_ldl, b_ldr, b_perr;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata, b_ldd;

  mem_unit #(.AW(AW), .DW(DW), .LOAD_BASE(0)) dut_a (
    .clk(clk), .reset(a_reset), .cpu_addr(a_addr), .cpu_we(a_we), .cpu_wdata(a_wdata),
    .cpu_rdata(a_rdata), .cpu_hold(a_hold), .ld_valid(a_ldv), .ld_data(a_ldd),
    .ld_last(a_ldl), .ld_ready(a_ldr), .perr(a_perr)
  );

  mem_unit #(.AW(AW), .DW(DW), .LOAD_BASE(32'hFFE)) dut_b (
    .clk(clk), .reset(b_reset), .cpu_addr(b_addr), .cpu_we(b_we), .cpu_wdata(b_wdata),
    .cpu_rdata(b_rdata), .cpu_hold(b_hold), .ld_valid(b_ldv), .ld_data(b_ldd),
    .ld_last(b_ldl), .ld_ready(b_ldr), .perr(b_perr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] ref_mem   [Depth];
  bit            ref_known [Depth];
  int            ref_ptr;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ldv;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_we = 1'b1; a_addr = '0; a_wdata = '0; a_ldv = 1'b0; a_ldd = '0; a_ldl = 1'b0;
  endtask

  task automatic a_read(input logic [AW-1:0] addr, input string name);
    a_we = 1'b1; a_addr = addr; a_ldv = 1'b0;
    #1;
    if (ref_known[addr]) chk(name, a_rdata, ref_mem[addr]);
    step();
  endtask

  task automatic a_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    a_we = 1'b0; a_addr = addr; a_wdata = data; a_ldv = 1'b0;
    #1;
    chk("wr_rdata_zero", a_rdata, 0);
    step();
    ref_mem[addr] = data; ref_known[addr] = 1'b1;
    a_we = 1'b1;
  endtask

  // Present a loader word for one cycle; the model records it at the current pointer.
  task automatic a_load(input logic [DW-1:0] data, input logic last);
    a_ldv = 1'b1; a_ldd = data; a_ldl = last;
    #1;
    chk("ld_ready_in_load", a_ldr, 1);
    chk("hold_in_load", a_hold, 1);
    step();
    ref_mem[ref_ptr] = data; ref_known[ref_ptr] = 1'b1; ref_ptr++;
    a_ldv = 1'b0; a_ldl = 1'b0;
  endtask

  task automatic a_reset_cycle();
    a_reset = 1'b1; a_ldv = 1'b0;
    step();
    a_reset = 1'b0;
    ref_ptr = 0;
  endtask

  initial begin
    logic [DW-1:0] w16;
    logic [AW-1:0] ad;
    int            n;
    int            sent;

    vecs[0]  = '{1'b0, 12'h010, 16'hBEEF, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 12'h010, 16'h0000, 1'b0, 16'hBEEF};
    vecs[2]  = '{1'b0, 12'h003, 16'h0001, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 12'hFFF, 16'hA5A5, 1'b1, 16'h0000};
    vecs[4]  = '{1'b0, 12'hFFF, 16'hA5A5, 1'b1, 16'h0000};
    vecs[5]  = '{1'b1, 12'hFFF, 16'h0000, 1'b1, 16'hA5A5};
    vecs[6]  = '{1'b1, 12'h003, 16'h0000, 1'b1, 16'h0001};
    vecs[7]  = '{1'b1, 12'h000, 16'h0000, 1'b0, 16'h1234};
    vecs[8]  = '{1'b1, 12'h002, 16'h0000, 1'b0, 16'h2FFF};
    vecs[9]  = '{1'b0, 12'h010, 16'h0BAD, 1'b0, 16'h0000};
    vecs[10] = '{1'b1, 12'h010, 16'h0000, 1'b0, 16'h0BAD};

    for (int i = 0; i < int'(Depth); i++) ref_known[i] = 1'b0;
    a_idle();
    a_reset = 1'b1;
    b_reset = 1'b1; b_we = 1'b1; b_addr = '0; b_wdata = '0; b_ldv = 1'b0; b_ldd = '0;
    b_ldl = 1'b0;
    step();

    // Reset state
    chk("rst_ld_ready", a_ldr, 0);
    chk("rst_hold", a_hold, 1);
    chk("rst_perr", a_perr, 0);
    chk("rst_rdata", a_rdata, 0);
    step();
    a_reset = 1'b0;
    ref_ptr = 0;
    #1;
    chk("load_ld_ready", a_ldr, 1);
    chk("load_hold", a_hold, 1);
    chk("load_rdata_zero", a_rdata, 0);

    // Three-word load ending on ld_last
    a_load(16'h1234, 1'b0);
    chk("hold_after_w0", a_hold, 1);
    a_load(16'h7002, 1'b0);
    chk("hold_after_w1", a_hold, 1);
    a_load(16'h2FFF, 1'b1);
    chk("hold_after_last", a_hold, 0);
    chk("ready_after_last", a_ldr, 0);
    for (int i = 0; i < 3; i++) a_read(AW'(i), $sformatf("load_rd%0d", i));

    // Directed RUN vectors; loader traffic here must be ignored
    for (int i = 0; i < 11; i++) begin
      a_we = vecs[i].we; a_addr = vecs[i].addr; a_wdata = vecs[i].wdata;
      a_ldv = vecs[i].ldv; a_ldd = 16'hDEAD; a_ldl = 1'b1;
      #1;
      chk($sformatf("vec%0d_rdata", i), a_rdata, vecs[i].exp);
      chk($sformatf("vec%0d_ready", i), a_ldr, 0);
      step();
      if (!vecs[i].we) begin
        ref_mem[vecs[i].addr] = vecs[i].wdata; ref_known[vecs[i].addr] = 1'b1;
      end
    end
    a_idle();

    // Random RUN traffic over a small address window
    for (int i = 0; i < 32; i++) a_write(AW'(i), 16'($urandom));
    for (int i = 0; i < 400; i++) begin
      ad = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        a_read(ad, "rand_rd");
      end else begin
        a_write(ad, 16'($urandom));
      end
    end

    // Parity: stored-bit corruption at 0x005
    a_read(12'h005, "par_rd_clean");
    chk("perr_clean", a_perr, 0);
`ifdef MEM_PARITY_EN
    dut_a.r_mem[5][0] = ~dut_a.r_mem[5][0];
    ref_mem[5][0] = ~ref_mem[5][0];
    a_read(12'h005, "par_rd_bad");
    chk("perr_set", a_perr, 1);
    for (int i = 0; i < 3; i++) step();
    chk("perr_sticky", a_perr, 1);
`else
    a_read(12'h005, "par_rd_again");
    for (int i = 0; i < 3; i++) step();
    chk("perr_tied_zero", a_perr, 0);
`endif

    // Reset in RUN with a CPU write attempt, then a CPU write while loading
    a_reset = 1'b1; a_we = 1'b0; a_addr = 12'h010; a_wdata = 16'hFFFF;
    #1;
    chk("run_rst_ready", a_ldr, 0);
    chk("run_rst_hold", a_hold, 1);
    step();
    a_reset = 1'b0; ref_ptr = 0;
    a_addr = 12'h011;
    #1;
    chk("reload_ready", a_ldr, 1);
    chk("reload_hold", a_hold, 1);
    chk("reload_perr", a_perr, 0);
    step();
    a_we = 1'b1;
    #1;
    chk("reload_rdata_zero", a_rdata, 0);

    // Reset after two of five loader words abandons the load
    a_load(16'h0A0A, 1'b0);
    a_load(16'h0B0B, 1'b0);
    a_ldv = 1'b1; a_ldd = 16'h0C0C; a_reset = 1'b1;
    #1;
    chk("midload_rst_ready", a_ldr, 0);
    step();
    a_reset = 1'b0; a_ldv = 1'b0; ref_ptr = 0;
    a_load(16'h0D0D, 1'b1);
    chk("midload_hold_done", a_hold, 0);
    a_read(12'h000, "midload_rd0");
    a_read(12'h001, "midload_rd1");
    a_read(12'h002, "midload_rd2");
    a_read(12'h010, "midload_rd10");
    a_read(12'h011, "midload_rd11");

    // Random-length load with random gaps in ld_valid
    a_reset_cycle();
    n = $urandom_range(3, 12);
    sent = 0;
    for (int cyc = 0; cyc < 100 && sent < n; cyc++) begin
      if ($urandom_range(0, 2) != 0) begin
        a_load(16'($urandom), (sent == n - 1));
        sent++;
        chk("rload_hold", a_hold, (sent == n) ? 0 : 1);
      end else begin
        step();
        chk("rload_gap_hold", a_hold, 1);
      end
    end
    chk("rload_words_sent", sent, n);
    for (int i = 0; i < 16; i++) a_read(AW'(i), "rload_rd");

    // Loader reaching the top address ends without wrapping
    step();
    b_reset = 1'b0;
    b_ldv = 1'b1; b_ldd = 16'h1111; b_ldl = 1'b1;
    step();
    b_ldv = 1'b0; b_ldl = 1'b0;
    b_we = 1'b0; b_addr = 12'h000; b_wdata = 16'h5555;
    step();
    b_we = 1'b1;
    b_reset = 1'b1;
    step();
    b_reset = 1'b0;
    b_ldv = 1'b1; b_ldd = 16'hAAAA;
    #1;
    chk("top_ready0", b_ldr, 1);
    step();
    chk("top_hold0", b_hold, 1);
    b_ldd = 16'hBBBB;
    step();
    chk("top_hold1", b_hold, 0);
    chk("top_ready1", b_ldr, 0);
    b_ldd = 16'hCCCC;
    #1;
    chk("top_ready2", b_ldr, 0);
    step();
    b_ldv = 1'b0;
    b_addr = 12'hFFE; #1; chk("top_rd_ffe", b_rdata, 16'hAAAA); step();
    b_addr = 12'hFFF; #1; chk("top_rd_fff", b_rdata, 16'hBBBB); step();
    b_addr = 12'h000; #1; chk("top_rd_000", b_rdata, 16'h5555); step();
    chk("b_perr", b_perr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1);
  end

endmodule
